// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 constants, word type, rotate/P1 helpers and expansion FSM states.
package sm3_pkg;
  localparam int WORD_W = 32;
  localparam int RNDS = 64;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic {ST_LOAD = 1'b0, ST_EXPND = 1'b1} state_t;
  function automatic word_t rotl(input word_t x, input int unsigned n);
    return word_t'((x << n) | (x >> (WORD_W - n)));
  endfunction
  function automatic word_t p1(input word_t x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction
endpackage

// File: rtl/sm3_expnd_wgen.sv
// sm3_expnd_wgen: combinational generator of W_{j+16} from the current expansion window taps.
module sm3_expnd_wgen
  import sm3_pkg::*;
(
  input  logic [WORD_W-1:0] w0_i,
  input  logic [WORD_W-1:0] w3_i,
  input  logic [WORD_W-1:0] w7_i,
  input  logic [WORD_W-1:0] w10_i,
  input  logic [WORD_W-1:0] w13_i,
  output logic [WORD_W-1:0] w16_o
);
  assign w16_o = p1(w0_i ^ w7_i ^ rotl(w13_i, 15)) ^ rotl(w3_i, 7) ^ w10_i;
endmodule

// File: rtl/sm3_expnd_core.sv
// sm3_expnd_core: SM3 message expansion, loads 16 words and streams 64 (W_j, W'_j) pairs.
// Define SM3_EXPND_PREFETCH_EN to add a shadow buffer that loads the next block during expansion.
module sm3_expnd_core
  import sm3_pkg::*;
#(
  parameter int EXPND_RNDS = RNDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] pad_inpt_d_i,
  input  logic              pad_inpt_vld_i,
  input  logic              pad_inpt_lst_i,
  output logic              pad_inpt_rdy_o,
  output logic [WORD_W-1:0] expnd_otpt_wj_o,
  output logic [WORD_W-1:0] expnd_otpt_wjj_o,
  output logic              expnd_otpt_lst_o,
  output logic              expnd_otpt_vld_o
);
  state_t      st_q, st_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [5:0]  rcnt_q, rcnt_d;
  word_t       win_q [16];
  word_t       win_d [16];
  logic        lst_q, lst_d;
  word_t       wnew;
  logic        hs;
  logic        last_rnd;
`ifdef SM3_EXPND_PREFETCH_EN
  word_t       sh_q [16];
  word_t       sh_d [16];
  logic [3:0]  swcnt_q, swcnt_d;
  logic        sfull_q, sfull_d;
  logic        slst_q, slst_d;
  assign pad_inpt_rdy_o = (st_q == ST_LOAD) | ~sfull_q;
`else
  assign pad_inpt_rdy_o = st_q == ST_LOAD;
`endif
  assign hs       = pad_inpt_vld_i & pad_inpt_rdy_o;
  assign last_rnd = rcnt_q == 6'(EXPND_RNDS - 1);

  sm3_expnd_wgen u_wgen (
    .w0_i  (win_q[0]),
    .w3_i  (win_q[3]),
    .w7_i  (win_q[7]),
    .w10_i (win_q[10]),
    .w13_i (win_q[13]),
    .w16_o (wnew)
  );

  always_comb begin
    st_d   = st_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    win_d  = win_q;
    lst_d  = lst_q;
`ifdef SM3_EXPND_PREFETCH_EN
    sh_d    = sh_q;
    swcnt_d = swcnt_q;
    sfull_d = sfull_q;
    slst_d  = slst_q;
    if (st_q == ST_EXPND && hs) begin
      sh_d[swcnt_q] = pad_inpt_d_i;
      swcnt_d       = swcnt_q + 4'd1;
      if (swcnt_q == 4'd15) begin
        sfull_d = 1'b1;
        slst_d  = pad_inpt_lst_i;
      end
    end
`endif
    if (st_q == ST_LOAD) begin
      if (hs) begin
        win_d[wcnt_q] = pad_inpt_d_i;
        wcnt_d        = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15) begin
          lst_d  = pad_inpt_lst_i;
          rcnt_d = '0;
          st_d   = ST_EXPND;
        end
      end
    end else begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = wnew;
      rcnt_d    = rcnt_q + 6'd1;
      if (last_rnd) begin
`ifdef SM3_EXPND_PREFETCH_EN
        // A partial shadow moves into the window so LOAD resumes at the same word index
        if (sfull_d) lst_d = slst_d;
        else begin
          st_d   = ST_LOAD;
          wcnt_d = swcnt_d;
        end
        win_d   = sh_d;
        swcnt_d = '0;
        sfull_d = 1'b0;
`else
        st_d = ST_LOAD;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_LOAD;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      win_q   <= '{default: '0};
      lst_q   <= 1'b0;
`ifdef SM3_EXPND_PREFETCH_EN
      sh_q    <= '{default: '0};
      swcnt_q <= '0;
      sfull_q <= 1'b0;
      slst_q  <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      win_q   <= win_d;
      lst_q   <= lst_d;
`ifdef SM3_EXPND_PREFETCH_EN
      sh_q    <= sh_d;
      swcnt_q <= swcnt_d;
      sfull_q <= sfull_d;
      slst_q  <= slst_d;
`endif
    end
  end

  assign expnd_otpt_wj_o  = win_q[0];
  assign expnd_otpt_wjj_o = win_q[0] ^ win_q[4];
  assign expnd_otpt_vld_o = st_q == ST_EXPND;
  assign expnd_otpt_lst_o = lst_q & expnd_otpt_vld_o;
endmodule

// File: tb/tb_sm3_expnd_core.sv
// tb_sm3_expnd_core: table-driven and randomized checks of sm3_expnd_core against an array-based SM3 expansion model.
module tb_sm3_expnd_core;
  typedef logic [31:0] word_t;
  typedef word_t blk_t [16];
  typedef struct {
    int    cyc;
    word_t wj;
    word_t wjj;
    logic  lst;
  } obs_t;
  typedef struct {
    int    rnd;
    word_t w;
    word_t wjj;
    bit    cwjj;
  } vec_t;

`ifdef SM3_EXPND_PREFETCH_EN
  localparam int   GAP_EXP  = 1;
  localparam logic RDY_EXPD = 1'b1;
`else
  localparam int   GAP_EXP  = 17;
  localparam logic RDY_EXPD = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst_n;
  word_t d_i;
  logic  vld_i, lst_i, rdy_o, vld_o, lst_o;
  word_t wj_o, wjj_o;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  obs_t  mon_q[$];
  word_t ref_w [68];
  word_t obs_w [64];
  word_t obs_wjj [64];

  sm3_expnd_core dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pad_inpt_d_i     (d_i),
    .pad_inpt_vld_i   (vld_i),
    .pad_inpt_lst_i   (lst_i),
    .pad_inpt_rdy_o   (rdy_o),
    .expnd_otpt_wj_o  (wj_o),
    .expnd_otpt_wjj_o (wjj_o),
    .expnd_otpt_lst_o (lst_o),
    .expnd_otpt_vld_o (vld_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (vld_o) mon_q.push_back('{cyc, wj_o, wjj_o, lst_o});

  function automatic word_t m_rotl(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook SM3 expansion: W_j from W_{j-16}, W_{j-13}, W_{j-9}, W_{j-6}, W_{j-3}
  function automatic void ref_expand(input blk_t m);
    word_t x;
    for (int j = 0; j < 16; j++) ref_w[j] = m[j];
    for (int j = 16; j < 68; j++) begin
      x = ref_w[j-16] ^ ref_w[j-9] ^ m_rotl(ref_w[j-3], 15);
      ref_w[j] = x ^ m_rotl(x, 15) ^ m_rotl(x, 23) ^ m_rotl(ref_w[j-13], 7) ^ ref_w[j-6];
    end
  endfunction

  task automatic chk(input string nm, input word_t act, input word_t exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic send_words(input blk_t m, input logic [15:0] lv, input int lo, input int hi,
                            input bit gaps, output int t_last);
    int to;
    int g;
    t_last = -1;
    for (int i = lo; i <= hi; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          vld_i = 1'b0;
        end
      end
      @(negedge clk);
      d_i   = m[i];
      vld_i = 1'b1;
      lst_i = lv[i];
      to    = 0;
      while (!rdy_o && to < 300) begin
        @(negedge clk);
        to++;
      end
      if (!rdy_o) begin
        n_vec++;
        n_err++;
        $display("FAIL rdy_timeout word %0d: rdy=%b expected 1", i, rdy_o);
      end
      t_last = cyc;
    end
    @(negedge clk);
    vld_i = 1'b0;
    lst_i = 1'b0;
  endtask

  task automatic check_block(input blk_t m, input logic lst_exp, input int first_exp,
                             output int first_obs, output int last_obs);
    int   to;
    obs_t e;
    ref_expand(m);
    first_obs = -1;
    last_obs  = -1;
    to = 0;
    while (mon_q.size() < 64 && to < 400) begin
      @(negedge clk);
      to++;
    end
    if (mon_q.size() < 64) begin
      n_vec++;
      n_err++;
      $display("FAIL vld_count: got %0d rounds expected 64", mon_q.size());
      mon_q.delete();
      return;
    end
    for (int j = 0; j < 64; j++) begin
      e = mon_q.pop_front();
      if (j == 0) first_obs = e.cyc;
      else chk("vld_contig", e.cyc, last_obs + 1);
      last_obs   = e.cyc;
      obs_w[j]   = e.wj;
      obs_wjj[j] = e.wjj;
      chk($sformatf("wj[%0d]", j), e.wj, ref_w[j]);
      chk($sformatf("wjj[%0d]", j), e.wjj, ref_w[j] ^ ref_w[j+4]);
      chk($sformatf("lst[%0d]", j), {31'b0, e.lst}, {31'b0, lst_exp});
    end
    if (first_exp >= 0) chk("first_vld_cycle", first_obs, first_exp);
  endtask

  task automatic rand_blk(output blk_t b);
    for (int i = 0; i < 16; i++) b[i] = $urandom;
  endtask

  initial begin
    vec_t tbl [10];
    blk_t abc, b1, b2;
    int   t, t2, f1, l1, f2, l2, to;
    tbl = '{'{0, 32'h61626380, 32'h61626380, 1'b1},
            '{1, 32'h00000000, 32'h00000000, 1'b1},
            '{12, 32'h00000000, 32'h9092e200, 1'b1},
            '{13, 32'h00000000, 32'h00000000, 1'b1},
            '{14, 32'h00000000, 32'h000c0606, 1'b1},
            '{15, 32'h00000018, 32'h719c70f5, 1'b1},
            '{16, 32'h9092e200, 32'h0, 1'b0},
            '{17, 32'h00000000, 32'h0, 1'b0},
            '{18, 32'h000c0606, 32'h0, 1'b0},
            '{19, 32'h719c70ed, 32'h0, 1'b0}};
    for (int i = 0; i < 16; i++) abc[i] = 32'h0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    rst_n = 1'b0;
    vld_i = 1'b0;
    lst_i = 1'b0;
    d_i   = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'b0, rdy_o}, 32'd1);
    chk("rst_vld", {31'b0, vld_o}, 32'd0);
    chk("rst_lst", {31'b0, lst_o}, 32'd0);
    chk("rst_wj", wj_o, 32'h0);
    chk("rst_wjj", wjj_o, 32'h0);
    rst_n = 1'b1;

    // "abc" block, gapless, then the known-answer table
    send_words(abc, 16'h8000, 0, 15, 1'b0, t);
    chk("rdy_during_expnd", {31'b0, rdy_o}, {31'b0, RDY_EXPD});
    check_block(abc, 1'b1, t + 1, f1, l1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("abc_w%0d", tbl[k].rnd), obs_w[tbl[k].rnd], tbl[k].w);
      if (tbl[k].cwjj) chk($sformatf("abc_wjj%0d", tbl[k].rnd), obs_wjj[tbl[k].rnd], tbl[k].wjj);
    end
    repeat (20) @(negedge clk);
    chk("no_extra_vld", mon_q.size(), 0);

    // Same block with random input gaps
    send_words(abc, 16'h8000, 0, 15, 1'b1, t);
    check_block(abc, 1'b1, t + 1, f1, l1);

    // Two consecutive blocks, first not last, second last
    rand_blk(b1);
    rand_blk(b2);
    send_words(b1, 16'h0000, 0, 15, 1'b0, t);
    send_words(b2, 16'h8000, 0, 15, 1'b0, t2);
    check_block(b1, 1'b0, t + 1, f1, l1);
    check_block(b2, 1'b1, -1, f2, l2);
    chk("block_gap", f2 - l1, GAP_EXP);
    repeat (20) @(negedge clk);

    // lst only on word 7 is ignored
    rand_blk(b1);
    send_words(b1, 16'h0080, 0, 15, 1'b1, t);
    check_block(b1, 1'b0, t + 1, f1, l1);
    repeat (5) @(negedge clk);

    // Reset mid-expansion
    rand_blk(b1);
    send_words(b1, 16'h8000, 0, 15, 1'b0, t);
    to = 0;
    while (mon_q.size() < 31 && to < 200) begin
      @(negedge clk);
      to++;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_vld", {31'b0, vld_o}, 32'd0);
    chk("midrst_lst", {31'b0, lst_o}, 32'd0);
    chk("midrst_wj", wj_o, 32'h0);
    chk("midrst_wjj", wjj_o, 32'h0);
    chk("midrst_rdy", {31'b0, rdy_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_q.delete();
    repeat (20) @(negedge clk);
    chk("postrst_no_vld", mon_q.size(), 0);
    rand_blk(b1);
    send_words(b1, 16'h8000, 0, 15, 1'b1, t);
    check_block(b1, 1'b1, t + 1, f1, l1);
    repeat (5) @(negedge clk);

`ifdef SM3_EXPND_PREFETCH_EN
    // Shadow only half full when round 63 is reached
    rand_blk(b1);
    rand_blk(b2);
    send_words(b1, 16'h0000, 0, 15, 1'b0, t);
    send_words(b2, 16'h8000, 0, 7, 1'b0, t2);
    check_block(b1, 1'b0, t + 1, f1, l1);
    repeat (3) @(negedge clk);
    chk("halfpf_vld_low", {31'b0, vld_o}, 32'd0);
    chk("halfpf_rdy", {31'b0, rdy_o}, 32'd1);
    send_words(b2, 16'h8000, 8, 15, 1'b0, t2);
    check_block(b2, 1'b1, t2 + 1, f2, l2);
    repeat (5) @(negedge clk);
`endif

    // Random blocks with random gaps
    for (int r = 0; r < 3; r++) begin
      rand_blk(b1);
      send_words(b1, {r[0], 15'h0}, 0, 15, 1'b1, t);
      check_block(b1, r[0], t + 1, f1, l1);
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
